// File: rtl/mu0_pkg.sv
// Shared widths, opcode and state encodings, and instruction field helpers for the MU0 CPU.
package mu0_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 12;

   typedef enum logic [3:0] {
      OP_LDA = 4'd0,
      OP_STA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_JMP = 4'd4,
      OP_JGE = 4'd5,
      OP_JNE = 4'd6,
      OP_STP = 4'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEMWAIT,
      ST_HALTED
   } state_e;

   function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] instr);
      return instr[DATA_W-1:DATA_W-4];
   endfunction

   function automatic logic [ADDR_W-1:0] operand_of(input logic [DATA_W-1:0] instr);
      return instr[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/mu0_alu.sv
// Accumulator update for the memory-operand instructions; other opcodes leave ACC unchanged.
module mu0_alu
   import mu0_pkg::*;
(
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] acc_next
);

   always_comb begin
      acc_next = acc;
      case (op)
         OP_LDA:  acc_next = mem_data;
         OP_ADD:  acc_next = acc + mem_data;
         OP_SUB:  acc_next = acc - mem_data;
         default: acc_next = acc;
      endcase
   end

endmodule

// File: rtl/cpu_mu0_delay1pl.sv
// Multi-cycle MU0 accumulator CPU for a dual-port RAM with one-cycle registered reads.
module cpu_mu0_delay1pl
   import mu0_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic              running,
   output logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] address2,
   output logic              write,
   output logic              read,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata,
   input  logic [DATA_W-1:0] readdata2
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   // Only the opcode of IR is needed after EXEC; the operand is consumed in that cycle.
   logic [3:0]        ir_op_q, ir_op_d;

   logic [3:0]        exec_op;
   logic [ADDR_W-1:0] exec_operand;
   logic [ADDR_W-1:0] pc_inc;
   logic [DATA_W-1:0] alu_result;

   mu0_alu u_alu (
      .op       (ir_op_q),
      .acc      (acc_q),
      .mem_data (readdata),
      .acc_next (alu_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         acc_q   <= '0;
         ir_op_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         ir_op_q <= ir_op_d;
      end
   end

   // EXEC decodes straight from the fetch port so the data access can start in the same cycle.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      acc_d        = acc_q;
      ir_op_d      = ir_op_q;
      address      = '0;
      read         = 1'b0;
      write        = 1'b0;
      exec_op      = opcode_of(readdata2);
      exec_operand = operand_of(readdata2);
      pc_inc       = pc_q + 12'd1;

      case (state_q)
         ST_FETCH: state_d = ST_EXEC;

         ST_EXEC: begin
            ir_op_d = exec_op;
            case (opcode_e'(exec_op))
               OP_LDA, OP_ADD, OP_SUB: begin
                  address = exec_operand;
                  read    = 1'b1;
                  state_d = ST_MEMWAIT;
               end
               OP_STA: begin
                  address = exec_operand;
                  write   = 1'b1;
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
               end
               OP_JMP: begin
                  pc_d    = exec_operand;
                  state_d = ST_FETCH;
               end
               OP_JGE: begin
                  pc_d    = acc_q[DATA_W-1] ? pc_inc : exec_operand;
                  state_d = ST_FETCH;
               end
               OP_JNE: begin
                  pc_d    = (acc_q != '0) ? exec_operand : pc_inc;
                  state_d = ST_FETCH;
               end
               default: state_d = ST_HALTED;
            endcase
         end

         ST_MEMWAIT: begin
            acc_d   = alu_result;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
         end

         ST_HALTED: state_d = ST_HALTED;

         default: state_d = ST_FETCH;
      endcase
   end

   assign running   = (state_q != ST_HALTED);
   assign address2  = pc_q;
   assign writedata = acc_q;

endmodule

// File: tb/tb_cpu_mu0_delay1pl.sv
// Directed bench for the MU0 CPU with an in-bench dual-port RAM model (registered reads, sync write).
module tb_cpu_mu0_delay1pl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        running;
   logic [11:0] address;
   logic [11:0] address2;
   logic        write;
   logic        read;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [15:0] readdata2;

   logic [15:0] mem [0:4095];
   logic        clr_en = 1'b0;
   logic        ld_en  = 1'b0;
   logic [11:0] ld_addr = '0;
   logic [15:0] ld_data = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [11:0] wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   logic [11:0] pc_trace  [$];
   int          run_edges;
   logic        halted;
   int          both_strobes;

   cpu_mu0_delay1pl dut (
      .clk       (clk),
      .rst       (rst),
      .running   (running),
      .address   (address),
      .address2  (address2),
      .write     (write),
      .read      (read),
      .writedata (writedata),
      .readdata  (readdata),
      .readdata2 (readdata2)
   );

   always #5 clk = ~clk;

   // RAM model: bench load/clear ports take priority over CPU writes; both read ports registered.
   always @(posedge clk) begin
      if (clr_en) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
      end else if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (write) begin
         mem[address] <= writedata;
      end
      readdata  <= mem[address];
      readdata2 <= mem[address2];
   end

   task automatic begin_program();
      rst = 1'b0;
      clr_en = 1'b1;
      @(posedge clk);
      #1 clr_en = 1'b0;
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Releases reset and records writes, PC trace and edge count until halt or budget.
   task automatic run_program(input int budget);
      wr_addr_q.delete();
      wr_data_q.delete();
      pc_trace.delete();
      run_edges = 0;
      halted = 1'b0;
      both_strobes = 0;
      @(negedge clk);
      rst = 1'b1;
      forever begin
         if (write) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(writedata);
         end
         if (read && write) both_strobes++;
         if (pc_trace.size() == 0 || pc_trace[$] !== address2) pc_trace.push_back(address2);
         if (running === 1'b0) begin
            halted = 1'b1;
            break;
         end
         if (run_edges >= budget) break;
         @(posedge clk);
         run_edges++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      begin_program();
      poke(12'h000, 16'h7000);
      repeat (2) begin
         @(negedge clk);
         vectors++; if (running !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_running: got %b expected 1", running); end
         vectors++; if (address2 !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_address2: got %h expected 000", address2); end
         vectors++; if (read !== 1'b0 || write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobes: got read=%b write=%b expected 0 0", read, write); end
         vectors++; if (address !== 12'h000 || writedata !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_data_port: got address=%h writedata=%h expected 000 0000", address, writedata); end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++; if (address2 !== 12'h000) begin miscompares++; $display("[TB] FAIL release_address2: got %h expected 000", address2); end
      @(negedge clk);
      vectors++; if (running !== 1'b1) begin miscompares++; $display("[TB] FAIL release_running_edge1: got %b expected 1", running); end
      @(negedge clk);
      vectors++; if (running !== 1'b0) begin miscompares++; $display("[TB] FAIL stp_halt: got running=%b expected 0", running); end
   endtask

   task automatic test_load_store();
      logic [11:0] a;
      logic [15:0] d;
      begin_program();
      poke(12'h000, 16'h0004);
      poke(12'h001, 16'h1005);
      poke(12'h002, 16'h7000);
      poke(12'h004, 16'h1234);
      run_program(40);
      a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 12'hxxx;
      d = (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx;
      vectors++; if (halted !== 1'b1 || run_edges != 7) begin miscompares++; $display("[TB] FAIL ldst_halt_edges: got halted=%b edges=%0d expected 1 7", halted, run_edges); end
      vectors++; if (wr_addr_q.size() != 1) begin miscompares++; $display("[TB] FAIL ldst_write_count: got %0d expected 1", wr_addr_q.size()); end
      vectors++; if (a !== 12'h005 || d !== 16'h1234) begin miscompares++; $display("[TB] FAIL ldst_write: got addr=%h data=%h expected 005 1234", a, d); end
      vectors++; if (mem[5] !== 16'h1234) begin miscompares++; $display("[TB] FAIL ldst_mem5: got %h expected 1234", mem[5]); end
      vectors++; if (both_strobes != 0) begin miscompares++; $display("[TB] FAIL ldst_exclusive_strobes: got %0d cycles expected 0", both_strobes); end
   endtask

   task automatic test_wraparound();
      begin_program();
      poke(12'h000, 16'h0010);
      poke(12'h001, 16'h2011);
      poke(12'h002, 16'h1012);
      poke(12'h003, 16'h7000);
      poke(12'h010, 16'hFFFF);
      poke(12'h011, 16'h0001);
      poke(12'h012, 16'h5A5A);
      run_program(40);
      vectors++; if (halted !== 1'b1 || run_edges != 10) begin miscompares++; $display("[TB] FAIL add_wrap_edges: got halted=%b edges=%0d expected 1 10", halted, run_edges); end
      vectors++; if (mem[12'h012] !== 16'h0000) begin miscompares++; $display("[TB] FAIL add_wrap_value: got %h expected 0000", mem[12'h012]); end

      begin_program();
      poke(12'h000, 16'h0010);
      poke(12'h001, 16'h3011);
      poke(12'h002, 16'h1012);
      poke(12'h003, 16'h7000);
      poke(12'h011, 16'h0001);
      run_program(40);
      vectors++; if (mem[12'h012] !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sub_wrap_value: got %h expected FFFF", mem[12'h012]); end
   endtask

   task automatic test_countdown();
      logic [15:0] exp_d [$];
      logic        bad;
      int          activity;
      exp_d = '{16'h0002, 16'h0001, 16'h0000};
      begin_program();
      poke(12'h000, 16'h000A);
      poke(12'h001, 16'h300B);
      poke(12'h002, 16'h100A);
      poke(12'h003, 16'h6001);
      poke(12'h004, 16'h7000);
      poke(12'h00A, 16'h0003);
      poke(12'h00B, 16'h0001);
      run_program(60);
      vectors++; if (halted !== 1'b1 || run_edges != 26) begin miscompares++; $display("[TB] FAIL countdown_edges: got halted=%b edges=%0d expected 1 26", halted, run_edges); end
      bad = (wr_addr_q.size() != 3);
      for (int i = 0; i < 3 && !bad; i++) bad = (wr_addr_q[i] !== 12'h00A) || (wr_data_q[i] !== exp_d[i]);
      vectors++; if (bad) begin miscompares++; $display("[TB] FAIL countdown_writes: got %0d writes first=%h expected 3 writes to 00A of 2,1,0", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 16'hxxxx); end
      activity = 0;
      repeat (5) begin
         @(negedge clk);
         if (read !== 1'b0 || write !== 1'b0 || running !== 1'b0 || address2 !== 12'h004 || address !== 12'h000) activity++;
      end
      vectors++; if (activity != 0) begin miscompares++; $display("[TB] FAIL halted_quiet: got %0d active cycles expected 0", activity); end
   endtask

   task automatic test_jumps();
      logic [11:0] exp_t [$];
      logic        bad;
      exp_t = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h020, 12'h021};
      begin_program();
      poke(12'h000, 16'h0010);
      poke(12'h001, 16'h1012);
      poke(12'h002, 16'h1013);
      poke(12'h003, 16'h5020);
      poke(12'h004, 16'h0011);
      poke(12'h005, 16'h5020);
      poke(12'h010, 16'h8000);
      poke(12'h011, 16'h0000);
      poke(12'h020, 16'h6030);
      poke(12'h021, 16'h7000);
      run_program(60);
      vectors++; if (halted !== 1'b1 || run_edges != 18) begin miscompares++; $display("[TB] FAIL jumps_edges: got halted=%b edges=%0d expected 1 18", halted, run_edges); end
      bad = (pc_trace.size() != exp_t.size());
      for (int i = 0; i < exp_t.size() && !bad; i++) bad = (pc_trace[i] !== exp_t[i]);
      vectors++; if (bad) begin miscompares++; $display("[TB] FAIL jumps_pc_trace: got %0d pcs last=%h expected 8 pcs ending 021", pc_trace.size(), (pc_trace.size() > 0) ? pc_trace[$] : 12'hxxx); end
   endtask

   task automatic test_pc_wrap();
      logic [11:0] exp_t [$];
      logic        bad;
      exp_t = '{12'h000, 12'hFFF, 12'h000, 12'h001};
      begin_program();
      poke(12'h000, 16'h4FFF);
      poke(12'hFFF, 16'h1000);
      poke(12'h001, 16'h7000);
      run_program(40);
      vectors++; if (halted !== 1'b1 || run_edges != 9) begin miscompares++; $display("[TB] FAIL pcwrap_edges: got halted=%b edges=%0d expected 1 9", halted, run_edges); end
      bad = (pc_trace.size() != exp_t.size());
      for (int i = 0; i < exp_t.size() && !bad; i++) bad = (pc_trace[i] !== exp_t[i]);
      vectors++; if (bad) begin miscompares++; $display("[TB] FAIL pcwrap_trace: got %0d pcs last=%h expected 4 pcs ending 001", pc_trace.size(), (pc_trace.size() > 0) ? pc_trace[$] : 12'hxxx); end

      begin_program();
      poke(12'h000, 16'h9000);
      run_program(20);
      vectors++; if (halted !== 1'b1 || run_edges != 2 || address2 !== 12'h000) begin miscompares++; $display("[TB] FAIL undefined_op_halt: got halted=%b edges=%0d pc=%h expected 1 2 000", halted, run_edges, address2); end
   endtask

   task automatic test_async_reset();
      begin_program();
      poke(12'h000, 16'h0004);
      poke(12'h001, 16'h0004);
      poke(12'h002, 16'h1005);
      poke(12'h003, 16'h7000);
      poke(12'h004, 16'h1234);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      vectors++; if (read !== 1'b1 || address !== 12'h004) begin miscompares++; $display("[TB] FAIL second_lda_read: got read=%b address=%h expected 1 004", read, address); end
      @(negedge clk);
      vectors++; if (address2 !== 12'h001 || writedata !== 16'h1234) begin miscompares++; $display("[TB] FAIL pre_reset_state: got pc=%h acc=%h expected 001 1234", address2, writedata); end
      #2 rst = 1'b0;
      #1;
      vectors++; if (read !== 1'b0 || write !== 1'b0 || address !== 12'h000) begin miscompares++; $display("[TB] FAIL async_strobes: got read=%b write=%b address=%h expected 0 0 000", read, write, address); end
      vectors++; if (writedata !== 16'h0000 || address2 !== 12'h000 || running !== 1'b1) begin miscompares++; $display("[TB] FAIL async_regs: got acc=%h pc=%h running=%b expected 0000 000 1", writedata, address2, running); end
      repeat (2) @(posedge clk);
      run_program(40);
      vectors++; if (halted !== 1'b1 || run_edges != 10 || pc_trace.size() == 0 || pc_trace[0] !== 12'h000) begin miscompares++; $display("[TB] FAIL rerun_edges: got halted=%b edges=%0d expected 1 10 from pc 000", halted, run_edges); end
      vectors++; if (wr_addr_q.size() != 1 || mem[5] !== 16'h1234) begin miscompares++; $display("[TB] FAIL rerun_store: got %0d writes mem5=%h expected 1 1234", wr_addr_q.size(), mem[5]); end
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_wraparound();
      test_countdown();
      test_jumps();
      test_pc_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cpu_mu0_delay1pl.md
Name: cpu_mu0_delay1pl

Overview:
- Multi-cycle MU0 accumulator CPU: 16-bit words, 12-bit word addresses, 4-bit opcode, 12-bit operand.
- Connects to a dual-read-port synchronous RAM (RAM_16x4096_delay1pl): 4096x16, one-cycle registered read latency.
- Port 2 (address2/readdata2) is read-only and used for instruction fetch.
- Port 1 (address/readdata) is used for data reads and writes.
- Runs from reset until STP, then reports running=0.

Parameters:
- none (fixed widths: DATA_W 16, ADDR_W 12, fixed in package)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- running  output  1  1 while executing; 0 once halted
- address  output  12  data-port address (port 1)
- address2  output  12  instruction-fetch address (port 2), always equals PC
- write  output  1  data-port write strobe; RAM writes writedata at address on this clock edge
- read  output  1  data-port read strobe
- writedata  output  16  store data, equal to ACC
- readdata  input  16  port-1 read data, valid the cycle after address/read were presented
- readdata2  input  16  port-2 read data, valid the cycle after address2 was presented

Behaviour:
- Registers: PC[11:0], ACC[15:0], IR[15:0], state.
- States: FETCH, EXEC, MEMWAIT, HALTED.
- Reset (rst=0, async): PC=0, ACC=0, IR=0, state=FETCH. Takes effect immediately, including mid-instruction.
- Output values while in reset: running=1, address2=0, address=0, read=0, write=0, writedata=0.
- running = (state != HALTED), combinational.
- FETCH: address2=PC. Next state EXEC.
- EXEC: IR captures readdata2 and is decoded combinationally from readdata2 in the same cycle. Opcode is bits [15:12], operand is bits [11:0].
  - 0 LDA, 2 ADD, 3 SUB: address=operand, read=1. Next state MEMWAIT.
  - 1 STA: address=operand, write=1, writedata=ACC. PC<=PC+1. Next state FETCH.
  - 4 JMP: PC<=operand. Next state FETCH.
  - 5 JGE: if ACC[15]==0 then PC<=operand, else PC<=PC+1. Next state FETCH.
  - 6 JNE: if ACC!=0 then PC<=operand, else PC<=PC+1. Next state FETCH.
  - 7 STP, and undefined opcodes 8-15: next state HALTED; PC unchanged.
- MEMWAIT: uses readdata and IR opcode.
  - LDA: ACC<=readdata.
  - ADD: ACC<=ACC+readdata.
  - SUB: ACC<=ACC-readdata.
  - PC<=PC+1. Next state FETCH.
  - read=0 and address=0 in this state.
- Arithmetic is 16-bit modulo: no flags, no carry retained.
- PC+1 wraps 0xFFF -> 0x000.
- Instruction latency:
  - LDA/ADD/SUB: 3 cycles.
  - STA/JMP/JGE/JNE: 2 cycles.
  - STP: running falls on the clock edge ending its EXEC cycle.
- HALTED: all strobes 0; state is held until rst is asserted.
- Default (inactive) outputs: address=0, read=0, write=0. writedata=ACC at all times.
- At most one of read/write is high in any cycle.
- A store to the next instruction's address is visible to its fetch, because the write commits before FETCH presents address2.

Decomposition:
- Package mu0_pkg:
  - opcode enum (LDA..STP)
  - state enum
  - DATA_W/ADDR_W constants
  - opcode/operand field slice helpers
- Optional sub-module mu0_alu: combinational; inputs op, acc, operand data; output new ACC.
- RAM_16x4096_delay1pl is a separate model used by the bench:
  - hex init file
  - synchronous write
  - registered reads on both ports

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> running=1, address2=0, read=0, write=0. First cycle after release shows address2=0; running still 1 one edge later.
2. Load/store: mem[0]=0x0004, [1]=0x1005, [2]=0x7000, [4]=0x1234 -> single write pulse with address=5, writedata=0x1234. mem[5]=0x1234. running falls 7 cycles after reset release.
3. Wraparound: program LDA 0xFFFF, ADD 1, STA, STP -> stored value 0x0000. Program LDA 0, SUB 1 -> stored value 0xFFFF.
4. Countdown: [0]=0x000A, [1]=0x300B, [2]=0x100A, [3]=0x6001, [4]=0x7000, [10]=3, [11]=1 -> writes to address 10 of 2, 1, 0 in order. Halts with running=0 after 26 cycles; no activity afterwards.
5. Jumps: ACC=0x8000 with JGE taken to 0x020 -> fetch continues at 0x004, not taken. ACC=0 -> JGE taken (address2=0x020), JNE not taken.
6. Async reset mid-LDA (rst=0 during MEMWAIT) -> strobes drop immediately, ACC=0. After release, re-fetch from address2=0 and the program completes normally.
